// File: rtl/octogen_pkg.sv
// Shared UDP-layer definitions: arbiter FSM states, header field widths and
// the packed UDP header payload used by the TX arbiter.
package octogen_pkg;

    localparam int unsigned IP_W   = 32;
    localparam int unsigned PORT_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [IP_W-1:0]   dest_ip;
        logic [PORT_W-1:0] src_port;
        logic [PORT_W-1:0] dest_port;
    } udp_hdr_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Scans req starting at last_grant+1, wrapping modulo NUM_SRC.
//   req        - request vector, one bit per source
//   last_grant - index of the most recently served source
//   found      - at least one request is set
//   idx        - first requesting index in round-robin order
module rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // First hit wins; later candidates are masked by found.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_SRC);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares the UDP TX header + 8-bit AXI-Stream payload path
// between NUM_SRC requesters, granting whole packets in round-robin order.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   s_hdr_valid/ready, s_dest_ip,
//   s_src_port, s_dest_port            - per-source header handshake + fields
//   s_tdata/tvalid/tlast/tready        - per-source payload stream
//   udp_tx_hdr_valid/ready, udp_tx_*   - shared header toward Ethernet I/O
//   udp_tx_tdata/tvalid/tlast/tready   - shared payload toward Ethernet I/O
//   grant_idx                          - current or most recent grant
//   busy                               - a grant is held
//   pkt_count                          - per-source 16-bit packet counters
//                                        (only with UDP_TX_ARB_STATS_EN)
module udp_tx_arbiter
    import octogen_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          s_hdr_valid,
    output logic [NUM_SRC-1:0]          s_hdr_ready,
    input  logic [IP_W*NUM_SRC-1:0]     s_dest_ip,
    input  logic [PORT_W*NUM_SRC-1:0]   s_src_port,
    input  logic [PORT_W*NUM_SRC-1:0]   s_dest_port,
    input  logic [DATA_W*NUM_SRC-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]          s_tvalid,
    input  logic [NUM_SRC-1:0]          s_tlast,
    output logic [NUM_SRC-1:0]          s_tready,
    output logic                        udp_tx_hdr_valid,
    input  logic                        udp_tx_hdr_ready,
    output logic [IP_W-1:0]             udp_tx_dest_ip,
    output logic [PORT_W-1:0]           udp_tx_src_port,
    output logic [PORT_W-1:0]           udp_tx_dest_port,
    output logic [DATA_W-1:0]           udp_tx_tdata,
    output logic                        udp_tx_tvalid,
    output logic                        udp_tx_tlast,
    input  logic                        udp_tx_tready,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        busy
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [CNT_W*NUM_SRC-1:0]    pkt_count
`endif
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic              tlast_fire;

    udp_hdr_t          hdr_arr  [NUM_SRC];
    logic [DATA_W-1:0] data_arr [NUM_SRC];

    // Unflatten per-source buses so muxing is a plain array index.
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign hdr_arr[g]  = {s_dest_ip[g*IP_W +: IP_W],
                              s_src_port[g*PORT_W +: PORT_W],
                              s_dest_port[g*PORT_W +: PORT_W]};
        assign data_arr[g] = s_tdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (s_hdr_valid),
        .last_grant (last_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // State, grant and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_SRC - 1);
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Next state plus combinational steering from the registered grant.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        tlast_fire       = 1'b0;
        s_hdr_ready      = '0;
        s_tready         = '0;
        udp_tx_hdr_valid = 1'b0;
        udp_tx_dest_ip   = '0;
        udp_tx_src_port  = '0;
        udp_tx_dest_port = '0;
        udp_tx_tdata     = '0;
        udp_tx_tvalid    = 1'b0;
        udp_tx_tlast     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                // A requester withdrawing here keeps its grant; valid just follows it.
                udp_tx_hdr_valid     = s_hdr_valid[grant_q];
                udp_tx_dest_ip       = hdr_arr[grant_q].dest_ip;
                udp_tx_src_port      = hdr_arr[grant_q].src_port;
                udp_tx_dest_port     = hdr_arr[grant_q].dest_port;
                s_hdr_ready[grant_q] = udp_tx_hdr_ready;
                if (udp_tx_hdr_valid && udp_tx_hdr_ready) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                udp_tx_tdata      = data_arr[grant_q];
                udp_tx_tvalid     = s_tvalid[grant_q];
                udp_tx_tlast      = s_tlast[grant_q];
                s_tready[grant_q] = udp_tx_tready;
                tlast_fire        = udp_tx_tvalid && udp_tx_tready && udp_tx_tlast;
                if (tlast_fire) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_idx = grant_q;

`ifdef UDP_TX_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_SRC];

    // Per-source completed-packet counters, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                cnt_q[i] <= '0;
            end
        end else if (tlast_fire) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
        assign pkt_count[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter (NUM_SRC = 4).
// Per-source packet generators feed the DUT; expected packets are pushed to a
// scoreboard queue when requests are issued and popped by an output monitor.
module tb_udp_tx_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_tvalid, s_tlast, s_tready;
    logic [32*N-1:0] s_dest_ip;
    logic [16*N-1:0] s_src_port, s_dest_port;
    logic [8*N-1:0]  s_tdata;
    logic            udp_tx_hdr_valid, udp_tx_hdr_ready;
    logic [31:0]     udp_tx_dest_ip;
    logic [15:0]     udp_tx_src_port, udp_tx_dest_port;
    logic [7:0]      udp_tx_tdata;
    logic            udp_tx_tvalid, udp_tx_tlast, udp_tx_tready;
    logic [IW-1:0]   grant_idx;
    logic            busy;
`ifdef UDP_TX_ARB_STATS_EN
    logic [16*N-1:0] pkt_count;
`endif

    udp_tx_arbiter #(.NUM_SRC(N), .IDX_W(IW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_hdr_valid      (s_hdr_valid),
        .s_hdr_ready      (s_hdr_ready),
        .s_dest_ip        (s_dest_ip),
        .s_src_port       (s_src_port),
        .s_dest_port      (s_dest_port),
        .s_tdata          (s_tdata),
        .s_tvalid         (s_tvalid),
        .s_tlast          (s_tlast),
        .s_tready         (s_tready),
        .udp_tx_hdr_valid (udp_tx_hdr_valid),
        .udp_tx_hdr_ready (udp_tx_hdr_ready),
        .udp_tx_dest_ip   (udp_tx_dest_ip),
        .udp_tx_src_port  (udp_tx_src_port),
        .udp_tx_dest_port (udp_tx_dest_port),
        .udp_tx_tdata     (udp_tx_tdata),
        .udp_tx_tvalid    (udp_tx_tvalid),
        .udp_tx_tlast     (udp_tx_tlast),
        .udp_tx_tready    (udp_tx_tready),
        .grant_idx        (grant_idx),
        .busy             (busy)
`ifdef UDP_TX_ARB_STATS_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] dp;
        int          len;
        logic [7:0]  base;
    } pkt_t;

    typedef struct {
        int       prior;
        logic [3:0] mask;
        int       n;
        int       order [4];
        int       len;
    } scen_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Source model state
    logic [31:0] cfg_ip   [N];
    logic [15:0] cfg_sp   [N];
    logic [15:0] cfg_dp   [N];
    logic [7:0]  cfg_base [N];
    int          sst       [N];
    int          beat      [N];
    int          plen      [N];
    int          pkts_left [N];
    logic [N-1:0] hs_hdr = '0;
    logic [N-1:0] hs_dat = '0;

    // Scoreboard / monitor state
    pkt_t exp_q [$];
    pkt_t cur;
    bit   in_pkt   = 0;
    int   mon_beat = 0;
    bit   leak     = 0;
    bit   gap_chk  = 0;
    bit   have_last = 0;
    int   ncyc     = 0;
    int   last_tlast_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_hdr_valid[i]        = (sst[i] == 1);
            s_tvalid[i]           = (sst[i] == 2);
            s_tlast[i]            = (sst[i] == 2) && (beat[i] == plen[i] - 1);
            s_tdata[i*8 +: 8]     = cfg_base[i] + 8'(beat[i]);
            s_dest_ip[i*32 +: 32] = cfg_ip[i];
            s_src_port[i*16 +: 16]  = cfg_sp[i];
            s_dest_port[i*16 +: 16] = cfg_dp[i];
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < N; i++) begin
            sst[i] = 0; beat[i] = 0; pkts_left[i] = 0; plen[i] = 1;
        end
        drive();
    endtask

    // Advance one cycle: consume handshakes seen at the last negedge, redrive.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (sst[i] == 1 && hs_hdr[i]) begin
                sst[i] = 2; beat[i] = 0;
            end else if (sst[i] == 2 && hs_dat[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    pkts_left[i]--;
                    sst[i] = 0;
                    beat[i] = 0;
                end
            end
            if (sst[i] == 0 && pkts_left[i] > 0) sst[i] = 1;
        end
        drive();
    endtask

    task automatic queue_pkt(input int src, input int len);
        pkts_left[src]++;
        plen[src] = len;
    endtask

    task automatic expect_pkt(input int src, input int len);
        pkt_t p;
        p.src = src; p.ip = cfg_ip[src]; p.sp = cfg_sp[src]; p.dp = cfg_dp[src];
        p.len = len; p.base = cfg_base[src];
        exp_q.push_back(p);
    endtask

    function automatic bit pending();
        bit r = (exp_q.size() != 0) || in_pkt;
        for (int i = 0; i < N; i++) if (pkts_left[i] > 0 || sst[i] != 0) r = 1;
        return r;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(k >= budget), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_clear();
        exp_q.delete();
        have_last = 0;
        gap_chk = 0;
        leak = 0;
        udp_tx_tready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Output monitor: header/payload scoreboard, grant isolation, idle gap.
    always @(negedge clk) begin
        hs_hdr = s_hdr_valid & s_hdr_ready;
        hs_dat = s_tvalid & s_tready;
        ncyc++;
        if (!rst_n) begin
            in_pkt = 0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (j != int'(grant_idx) && (s_hdr_ready[j] || s_tready[j])) leak = 1;
            end
            if (udp_tx_hdr_valid && udp_tx_hdr_ready) begin
                if (exp_q.size() == 0) begin
                    check("hdr_unexpected", 32'(grant_idx), 32'hFFFF_FFFF);
                end else begin
                    cur = exp_q.pop_front();
                    check("hdr_src", 32'(grant_idx), 32'(cur.src));
                    check("hdr_ip", udp_tx_dest_ip, cur.ip);
                    check("hdr_sport", 32'(udp_tx_src_port), 32'(cur.sp));
                    check("hdr_dport", 32'(udp_tx_dest_port), 32'(cur.dp));
                    if (gap_chk && have_last) check("idle_gap", 32'(ncyc - last_tlast_cyc), 32'd2);
                    in_pkt = 1;
                    mon_beat = 0;
                end
            end
            if (udp_tx_tvalid && udp_tx_tready) begin
                if (!in_pkt) begin
                    check("beat_unexpected", 32'(udp_tx_tdata), 32'hFFFF_FFFF);
                end else begin
                    check("tdata", 32'(udp_tx_tdata), 32'(cur.base + 8'(mon_beat)));
                    check("tlast", 32'(udp_tx_tlast), 32'(mon_beat == cur.len - 1));
                    mon_beat++;
                    if (udp_tx_tlast) begin
                        in_pkt = 0;
                        check("grant_isolation", 32'(leak), 32'd0);
                        last_tlast_cyc = ncyc;
                        have_last = 1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t scen [5];
        int k;
        logic [3:0] pat;

        scen[0] = '{prior: -1, mask: 4'b1111, n: 4, order: '{0, 1, 2, 3}, len: 3};
        scen[1] = '{prior:  3, mask: 4'b1001, n: 2, order: '{0, 3, 0, 0}, len: 2};
        scen[2] = '{prior:  1, mask: 4'b1101, n: 3, order: '{2, 3, 0, 0}, len: 2};
        scen[3] = '{prior:  0, mask: 4'b0011, n: 2, order: '{1, 0, 0, 0}, len: 1};
        scen[4] = '{prior:  2, mask: 4'b1010, n: 2, order: '{3, 1, 0, 0}, len: 4};

        for (int i = 0; i < N; i++) begin
            cfg_ip[i]   = 32'h0A00_0000 + 32'(i);
            cfg_sp[i]   = 16'(1000 + i);
            cfg_dp[i]   = 16'(2000 + i);
            cfg_base[i] = 8'(16 + 32 * i);
        end
        cfg_ip[2] = 32'hC0A8_010A; cfg_sp[2] = 16'd5000; cfg_dp[2] = 16'd6000; cfg_base[2] = 8'hA1;

        udp_tx_hdr_ready = 1'b1;
        udp_tx_tready    = 1'b1;
        src_clear();

        // Reset values while reset is held
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_idx), 32'd0);
        check("rst_hdr_valid", 32'(udp_tx_hdr_valid), 32'd0);
        check("rst_tvalid", 32'(udp_tx_tvalid), 32'd0);
        check("rst_readies", 32'({s_hdr_ready, s_tready}), 32'd0);
        check("rst_data", udp_tx_dest_ip | 32'(udp_tx_tdata), 32'd0);
        do_reset();

        // Single source 2: grant latency and field passthrough
        queue_pkt(2, 4);
        expect_pkt(2, 4);
        tick();
        @(negedge clk);
        check("lat_idle_valid", 32'(udp_tx_hdr_valid), 32'd0);
        check("lat_idle_busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        check("lat_hdr_valid", 32'(udp_tx_hdr_valid), 32'd1);
        check("lat_grant", 32'(grant_idx), 32'd2);
        check("lat_busy", 32'(busy), 32'd1);
        wait_done("single_timeout", 40);
        check("single_grant_kept", 32'(grant_idx), 32'd2);
        check("single_busy_end", 32'(busy), 32'd0);

        // Round-robin order table
        for (int s = 0; s < 5; s++) begin
            do_reset();
            if (scen[s].prior >= 0) begin
                queue_pkt(scen[s].prior, 2);
                expect_pkt(scen[s].prior, 2);
                wait_done("prior_timeout", 40);
            end
            have_last = 0;
            gap_chk = 1;
            for (int i = 0; i < N; i++) if (scen[s].mask[i]) queue_pkt(i, scen[s].len);
            for (int i = 0; i < scen[s].n; i++) expect_pkt(scen[s].order[i], scen[s].len);
            wait_done("table_timeout", 120);
            gap_chk = 0;
        end

        // Backpressure mid-packet while another source waits
        do_reset();
        queue_pkt(1, 6);
        expect_pkt(1, 6);
        k = 0;
        while (!(in_pkt && mon_beat >= 1) && k < 40) begin tick(); k++; end
        check("bp_start_timeout", 32'(k >= 40), 32'd0);
        queue_pkt(3, 2);
        expect_pkt(3, 2);
        pat = 4'b1001;
        for (int i = 3; i >= 0; i--) begin
            tick();
            udp_tx_tready = pat[i];
            @(negedge clk);
            check("bp_tready_src1", 32'(s_tready[1]), 32'(pat[i]));
            check("bp_blocked_src3", 32'({s_tready[3], s_hdr_ready[3]}), 32'd0);
        end
        tick();
        udp_tx_tready = 1'b1;
        wait_done("bp_timeout", 80);

        // Reset pulse on beat 2 of a 5-beat packet
        do_reset();
        queue_pkt(1, 5);
        expect_pkt(1, 5);
        k = 0;
        while (!(in_pkt && mon_beat == 2) && k < 40) begin tick(); k++; end
        check("mid_rst_timeout", 32'(k >= 40), 32'd0);
        check("mid_rst_pre_tvalid", 32'(udp_tx_tvalid), 32'd1);
        #2 rst_n = 1'b0;
        src_clear();
        exp_q.delete();
        #1;
        check("mid_rst_tvalid", 32'(udp_tx_tvalid), 32'd0);
        check("mid_rst_hdr_valid", 32'(udp_tx_hdr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tready", 32'(s_tready), 32'd0);
        tick();
        rst_n = 1'b1;
        queue_pkt(2, 3);
        queue_pkt(0, 3);
        expect_pkt(0, 3);
        expect_pkt(2, 3);
        wait_done("post_rst_timeout", 60);

`ifdef UDP_TX_ARB_STATS_EN
        // Packet counters
        do_reset();
        queue_pkt(0, 2);
        queue_pkt(1, 2); queue_pkt(1, 2); queue_pkt(1, 2);
        expect_pkt(0, 2);
        expect_pkt(1, 2); expect_pkt(1, 2); expect_pkt(1, 2);
        wait_done("stats_timeout", 100);
        check("cnt_src0", 32'(pkt_count[15:0]), 32'd1);
        check("cnt_src1", 32'(pkt_count[31:16]), 32'd3);
        check("cnt_src2", 32'(pkt_count[47:32]), 32'd0);
        check("cnt_src3", 32'(pkt_count[63:48]), 32'd0);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
